// File: rtl/pa_rvfpm.sv
// Shared types for the rvfpm XIF issue/commit queue.
// Entry state encoding, payload bundle and default geometry.
package pa_rvfpm;

   localparam int unsigned XIF_DEPTH = 4;
   localparam int unsigned XIF_ID_W  = 4;
   localparam int unsigned XIF_FLEN  = 32;
   localparam int unsigned XIF_NRS   = 3;
   localparam int unsigned PTR_W     = $clog2(XIF_DEPTH);

   typedef enum logic [1:0] {
      E_EMPTY,
      E_PENDING,
      E_COMMITTED,
      E_KILLED
   } ent_st_e;

   typedef struct packed {
      logic [31:0]                  instr;
      logic [XIF_ID_W-1:0]          id;
      logic [XIF_NRS*XIF_FLEN-1:0]  rs;
      logic [1:0]                   mode;
   } ent_pl_t;

   function automatic ent_st_e resolve_st(input logic kill);
      return kill ? E_KILLED : E_COMMITTED;
   endfunction

endpackage

// File: rtl/rvfpm_early_commit_table.sv
// Per-id {valid, kill} record of commits that beat their issue.
// Only present when RVFPM_EARLY_COMMIT_EN is defined.
`ifdef RVFPM_EARLY_COMMIT_EN
module rvfpm_early_commit_table #(
   parameter int unsigned X_ID_WIDTH = 4
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [X_ID_WIDTH-1:0] set_id,
   input  logic                  set_kill,
   input  logic                  clr_en,
   input  logic [X_ID_WIDTH-1:0] clr_id,
   input  logic [X_ID_WIDTH-1:0] look_id,
   output logic                  hit,
   output logic                  hit_kill
);

   localparam int unsigned N = 1 << X_ID_WIDTH;

   logic [N-1:0] vld_q;
   logic [N-1:0] kil_q;

   assign hit      = vld_q[look_id];
   assign hit_kill = kil_q[look_id];

   always_ff @(posedge ck) begin
      if (rst) begin
         vld_q <= '0;
         kil_q <= '0;
      end else begin
         if (clr_en) vld_q[clr_id] <= 1'b0;
         if (set_en) begin
            vld_q[set_id] <= 1'b1;
            kil_q[set_id] <= set_kill;
         end
      end
   end

endmodule
`endif

// File: rtl/rvfpm_xif_issue_queue.sv
// In-order XIF issue/commit queue feeding the rvfpm execute stage.
// Optional early-commit id table: RVFPM_EARLY_COMMIT_EN.
module rvfpm_xif_issue_queue
   import pa_rvfpm::*;
#(
   parameter int unsigned DEPTH      = XIF_DEPTH,
   parameter int unsigned X_ID_WIDTH = XIF_ID_W,
   parameter int unsigned FLEN       = XIF_FLEN,
   parameter int unsigned X_NUM_RS   = XIF_NRS
) (
   input  logic                       ck,
   input  logic                       rst,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [31:0]                issue_instr,
   input  logic [X_ID_WIDTH-1:0]      issue_id,
   input  logic [X_NUM_RS*FLEN-1:0]   issue_rs,
   input  logic [1:0]                 issue_mode,
   input  logic                       commit_valid,
   input  logic [X_ID_WIDTH-1:0]      commit_id,
   input  logic                       commit_kill,
   output logic                       ex_valid,
   input  logic                       ex_ready,
   output logic [31:0]                ex_instr,
   output logic [X_ID_WIDTH-1:0]      ex_id,
   output logic [X_NUM_RS*FLEN-1:0]   ex_rs,
   output logic [1:0]                 ex_mode,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   ent_st_e       st_q [DEPTH];
   ent_pl_t       pl_q [DEPTH];
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] cnt_q;

   logic    accept;
   logic    drop;
   logic    pop;
   logic    tbl_hit;
   logic    tbl_kill;
   ent_st_e push_st;

   assign full        = (cnt_q == CW'(DEPTH));
   assign empty       = (cnt_q == '0);
   assign count       = cnt_q;
   assign issue_ready = !full && !rst;
   assign accept      = issue_valid && issue_ready;

   assign ex_valid = (st_q[head_q] == E_COMMITTED);
   assign drop     = (st_q[head_q] == E_KILLED);
   assign pop      = (ex_valid && ex_ready) || drop;
   assign ex_instr = pl_q[head_q].instr;
   assign ex_id    = pl_q[head_q].id;
   assign ex_rs    = pl_q[head_q].rs;
   assign ex_mode  = pl_q[head_q].mode;

`ifdef RVFPM_EARLY_COMMIT_EN
   logic [DEPTH-1:0] id_seen;
   logic             tbl_set;

   always_comb begin
      id_seen = '0;
      for (int i = 0; i < DEPTH; i++) begin
         id_seen[i] = (st_q[i] != E_EMPTY) && (pl_q[i].id == commit_id);
      end
   end

   // A commit that lands on neither a queued nor an arriving id is parked
   assign tbl_set = commit_valid && !(|id_seen) &&
                    !(accept && (issue_id == commit_id));

   rvfpm_early_commit_table #(
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_tbl (
      .ck       (ck),
      .rst      (rst),
      .set_en   (tbl_set),
      .set_id   (commit_id),
      .set_kill (commit_kill),
      .clr_en   (accept),
      .clr_id   (issue_id),
      .look_id  (issue_id),
      .hit      (tbl_hit),
      .hit_kill (tbl_kill)
   );
`else
   assign tbl_hit  = 1'b0;
   assign tbl_kill = 1'b0;
`endif

   // A same-cycle commit outranks a parked early commit
   always_comb begin
      push_st = E_PENDING;
      if (commit_valid && (commit_id == issue_id)) begin
         push_st = resolve_st(commit_kill);
      end else if (tbl_hit) begin
         push_st = resolve_st(tbl_kill);
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i] <= E_EMPTY;
            pl_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && (st_q[i] == E_PENDING) &&
                (pl_q[i].id == commit_id)) begin
               st_q[i] <= resolve_st(commit_kill);
            end
         end
         if (pop) begin
            st_q[head_q] <= E_EMPTY;
            head_q       <= head_q + PW'(1);
         end
         if (accept) begin
            st_q[tail_q] <= push_st;
            pl_q[tail_q] <= '{instr: issue_instr, id: issue_id,
                              rs: issue_rs, mode: issue_mode};
            tail_q       <= tail_q + PW'(1);
         end
         case ({accept, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_rvfpm_xif_issue_queue.sv
// Self-checking bench for rvfpm_xif_issue_queue.
// Queue-level reference model, directed scenarios, then random traffic.
module tb_rvfpm_xif_issue_queue;

   localparam int DEPTH = 4;
   localparam int IDW   = 4;
   localparam int FLEN  = 32;
   localparam int NRS   = 3;

   logic              ck = 1'b0;
   logic              rst = 1'b1;
   logic              issue_valid;
   logic              issue_ready;
   logic [31:0]       issue_instr;
   logic [IDW-1:0]    issue_id;
   logic [NRS*FLEN-1:0] issue_rs;
   logic [1:0]        issue_mode;
   logic              commit_valid;
   logic [IDW-1:0]    commit_id;
   logic              commit_kill;
   logic              ex_valid;
   logic              ex_ready;
   logic [31:0]       ex_instr;
   logic [IDW-1:0]    ex_id;
   logic [NRS*FLEN-1:0] ex_rs;
   logic [1:0]        ex_mode;
   logic [2:0]        count;
   logic              empty;
   logic              full;

   always #5 ck = ~ck;

   rvfpm_xif_issue_queue #(
      .DEPTH(DEPTH), .X_ID_WIDTH(IDW), .FLEN(FLEN), .X_NUM_RS(NRS)
   ) dut (
      .ck(ck), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_instr(issue_instr), .issue_id(issue_id),
      .issue_rs(issue_rs), .issue_mode(issue_mode),
      .commit_valid(commit_valid), .commit_id(commit_id),
      .commit_kill(commit_kill),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_instr(ex_instr), .ex_id(ex_id), .ex_rs(ex_rs),
      .ex_mode(ex_mode),
      .count(count), .empty(empty), .full(full)
   );

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: st 1=pending 2=committed 3=killed
   typedef struct {
      logic [31:0]         instr;
      logic [IDW-1:0]      id;
      logic [NRS*FLEN-1:0] rs;
      logic [1:0]          mode;
      int                  st;
   } ment_t;

   ment_t mq[$];
   bit    ev[16];
   bit    ek[16];
   bit    started = 0;
   bit    m_acc, m_match, m_pop;
   int    m_st;
   ment_t m_new;

   always @(posedge ck) begin
      started <= 1;
      if (rst) begin
         mq.delete();
         for (int i = 0; i < 16; i++) ev[i] = 0;
      end else begin
         m_acc   = issue_valid && (mq.size() < DEPTH);
         m_match = 0;
         m_pop   = (mq.size() > 0) &&
                   ((mq[0].st == 2 && ex_ready) || mq[0].st == 3);
         foreach (mq[i]) begin
            if (mq[i].id == commit_id) begin
               m_match = 1;
               if (commit_valid && mq[i].st == 1)
                  mq[i].st = commit_kill ? 3 : 2;
            end
         end
         if (m_pop) void'(mq.pop_front());
         if (m_acc) begin
            m_st = 1;
            if (commit_valid && commit_id == issue_id)
               m_st = commit_kill ? 3 : 2;
            else if (ev[issue_id])
               m_st = ek[issue_id] ? 3 : 2;
            m_new.instr = issue_instr;
            m_new.id    = issue_id;
            m_new.rs    = issue_rs;
            m_new.mode  = issue_mode;
            m_new.st    = m_st;
            mq.push_back(m_new);
            ev[issue_id] = 0;
         end
`ifdef RVFPM_EARLY_COMMIT_EN
         if (commit_valid && !m_match && !(m_acc && issue_id == commit_id)) begin
            ev[commit_id] = 1;
            ek[commit_id] = commit_kill;
         end
`endif
      end
   end

   bit e_v;
   always @(negedge ck) begin
      if (started) begin
         e_v = (mq.size() > 0) && (mq[0].st == 2);
         chk("ex_valid", ex_valid, e_v);
         if (e_v) begin
            chk("ex_instr", ex_instr, mq[0].instr);
            chk("ex_id", ex_id, mq[0].id);
            chk("ex_rs", ex_rs, mq[0].rs);
            chk("ex_mode", ex_mode, mq[0].mode);
         end
         chk("count", count, mq.size());
         chk("empty", empty, mq.size() == 0);
         chk("full", full, mq.size() == DEPTH);
         chk("issue_ready", issue_ready, (mq.size() != DEPTH) && !rst);
      end
   end

   task automatic idle();
      issue_valid  = 0;
      commit_valid = 0;
      commit_kill  = 0;
   endtask

   task automatic tick();
      @(posedge ck);
      @(negedge ck);
      #2;
   endtask

   task automatic iss(input int id, input logic [31:0] instr,
                      input logic [31:0] rs0);
      issue_valid = 1;
      issue_id    = IDW'(id);
      issue_instr = instr;
      issue_rs    = {32'hC0000000, 32'h40000000, rs0};
      issue_mode  = 2'd3;
   endtask

   task automatic cmt(input int id, input logic kill);
      commit_valid = 1;
      commit_id    = IDW'(id);
      commit_kill  = kill;
   endtask

   function automatic bit in_q(input logic [IDW-1:0] id);
      foreach (mq[i]) if (mq[i].id == id) return 1;
      return 0;
   endfunction

   logic [IDW-1:0] rid;

   initial begin
      idle();
      ex_ready    = 0;
      issue_instr = '0;
      issue_id    = '0;
      issue_rs    = '0;
      issue_mode  = '0;
      commit_id   = '0;
      #1;
      chk("rdy_in_reset", issue_ready, 0);
      tick();
      rst = 0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_instr", ex_instr, 0);
      chk("rst_ex_rs", ex_rs, 0);
      chk("rst_ex_id", ex_id, 0);
      chk("rst_ready", issue_ready, 1);

      // same-cycle issue+commit, one-cycle latency
      ex_ready = 1;
      iss(3, 32'h00B57553, 32'h3F800000);
      cmt(3, 0);
      tick();
      idle();
      chk("t1_valid", ex_valid, 1);
      chk("t1_id", ex_id, 3);
      chk("t1_rs0", ex_rs[31:0], 32'h3F800000);
      chk("t1_instr", ex_instr, 32'h00B57553);
      tick();
      chk("t1_count", count, 0);

      // fill, then out-of-order commits
      for (int i = 0; i < 4; i++) begin
         iss(i, 32'h1000 + i, 32'h100 + i);
         tick();
      end
      idle();
      chk("t2_full", full, 1);
      chk("t2_ready", issue_ready, 0);
      chk("t2_valid", ex_valid, 0);
      cmt(1, 0);
      tick();
      chk("t2_wait_head", ex_valid, 0);
      cmt(0, 0);
      tick();
      idle();
      chk("t2_first", ex_id, 0);
      tick();
      chk("t2_second_v", ex_valid, 1);
      chk("t2_second", ex_id, 1);
      tick();
      chk("t2_rem", count, 2);
      cmt(2, 1);
      tick();
      cmt(3, 1);
      tick();
      idle();
      tick();
      chk("t2_drained", count, 0);

      // kill then commit
      iss(5, 32'h5, 32'h5);
      tick();
      iss(6, 32'h6, 32'h6);
      tick();
      idle();
      cmt(5, 1);
      tick();
      chk("t3_killed_v", ex_valid, 0);
      cmt(6, 0);
      tick();
      idle();
      chk("t3_v", ex_valid, 1);
      chk("t3_id", ex_id, 6);
      tick();
      chk("t3_count", count, 0);

      // stall with stable payload; a late kill must not retract it
      ex_ready = 0;
      iss(9, 32'h9999, 32'h9);
      cmt(9, 0);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) cmt(9, 1);
         tick();
         idle();
         chk("t4_stall_v", ex_valid, 1);
         chk("t4_stall_id", ex_id, 9);
         chk("t4_stall_instr", ex_instr, 32'h9999);
      end
      ex_ready = 1;
      tick();
      chk("t4_popped", count, 0);

      // early commit
      ex_ready = 0;
      cmt(7, 0);
      tick();
      idle();
      tick();
      iss(7, 32'h7777, 32'h7);
      tick();
      idle();
`ifdef RVFPM_EARLY_COMMIT_EN
      chk("t5_early_v", ex_valid, 1);
`else
      chk("t5_pending_v", ex_valid, 0);
      chk("t5_pending_cnt", count, 1);
      cmt(7, 0);
      tick();
      idle();
      chk("t5_late_v", ex_valid, 1);
`endif
      ex_ready = 1;
      tick();
      chk("t5_count", count, 0);

      // reset with entries queued and an early commit parked
      for (int i = 10; i < 13; i++) begin
         iss(i, 32'(i), 32'(i));
         tick();
      end
      idle();
      cmt(13, 0);
      tick();
      idle();
      chk("t6_pre", count, 3);
      rst = 1;
      tick();
      rst = 0;
      chk("t6_count", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_valid", ex_valid, 0);
      iss(13, 32'hD, 32'hD);
      tick();
      idle();
      chk("t6_tbl_clear", ex_valid, 0);
      cmt(13, 1);
      tick();
      idle();
      tick();
      chk("t6_drained", count, 0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 199) == 0);
         issue_valid = $urandom_range(0, 1);
         do rid = IDW'($urandom_range(0, 15)); while (in_q(rid));
         issue_id    = rid;
         issue_instr = $urandom;
         issue_rs    = {$urandom, $urandom, $urandom};
         issue_mode  = 2'($urandom_range(0, 3));
         commit_valid = $urandom_range(0, 1);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            commit_id = mq[$urandom_range(0, mq.size() - 1)].id;
         else
            commit_id = IDW'($urandom_range(0, 15));
         commit_kill = ($urandom_range(0, 3) == 0);
         ex_ready    = ($urandom_range(0, 3) != 0);
         tick();
      end
      idle();
      rst = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/rvfpm_xif_issue_queue.md
# rvfpm_xif_issue_queue

Synthesizable, parametrised CORE-V-XIF issue/commit queue for the rvfpm coprocessor. Buffers accepted issue transactions with their operands and releases them in order to the execute pipeline only once the core has committed them; killed instructions are discarded without execution. It sits between the XIF issue/commit interfaces and the FPU execute stage. It also supports commits that arrive before the matching issue is accepted.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- X_ID_WIDTH, 4: instruction id width
- FLEN, 32: operand width
- X_NUM_RS, 3: operands per instruction
- ck  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- issue_valid  in  1  issue request valid
- issue_ready  out  1  queue can accept
- issue_instr  in  32  instruction word
- issue_id  in  X_ID_WIDTH  instruction id
- issue_rs  in  X_NUM_RS*FLEN  operands; rs[i] at bits [i*FLEN +: FLEN]
- issue_mode  in  2  privilege mode
- commit_valid  in  1  commit transaction valid
- commit_id  in  X_ID_WIDTH  committed/killed id
- commit_kill  in  1  1 = kill, 0 = commit
- ex_valid  out  1  head instruction ready for execute
- ex_ready  in  1  execute stage accepts
- ex_instr / ex_id / ex_rs / ex_mode  out  widths as issue side  head entry payload
- count  out  $clog2(DEPTH)+1  occupied entries
- empty, full  out  1  occupancy flags

## Operation
- Entry state: EMPTY, PENDING, COMMITTED, KILLED. Circular buffer; head/tail pointers wrap modulo DEPTH.
- Accept on issue_valid && issue_ready; issue_ready = !full (no push-through when full, even if head pops the same cycle).
- Accepted entry is written at tail as PENDING, or directly as COMMITTED/KILLED if a commit for issue_id is present in the same cycle or recorded early (see Configuration).
- Commit: commit_valid with commit_id matching a PENDING entry moves it to COMMITTED (kill=0) or KILLED (kill=1). Entries in other states are not modified.
- Head COMMITTED: ex_valid=1, payload from head. Pop on ex_valid && ex_ready.
- Head KILLED: dropped in one cycle, ex_valid stays 0, no execute transfer.
- Head PENDING: ex_valid=0; entries behind it wait even if committed (strict in-order).
- Push and pop in the same cycle: count unchanged.
- Duplicate in-flight ids are illegal. The core guarantees they do not occur. Behaviour is undefined and not checked.

## Timing
- Reset: all entries EMPTY, pointers 0, count=0, empty=1, full=0, ex_valid=0, ex_* payload 0, issue_ready=0 during reset cycle then 1, early table cleared.
- ex_valid and ex_* come directly from registered state (no input→output combinational path, except issue_ready from full).
- Minimum latency: issue accepted with commit in the same cycle N → ex_valid high in cycle N+1.
- ex_valid stays high with a stable payload until ex_ready. Payload is not retracted by a later kill, because only PENDING entries change state.
- Killed head consumes one cycle of drain.
- Reset mid-operation: all state discarded in that cycle; no ex transfer that cycle.

## Configuration
- RVFPM_EARLY_COMMIT_EN defined:
  - Add a 2^X_ID_WIDTH-entry table of {valid, kill} bits.
  - A commit whose id matches no queued entry and is not being issued that cycle sets the table entry for that id.
  - A later accepted issue with that id enters COMMITTED/KILLED directly and clears the table bit in the same cycle.
  - A table hit and a new commit for the same id in the same cycle: the new commit wins.
- RVFPM_EARLY_COMMIT_EN undefined: unmatched commits are ignored, the table is absent, and the entry waits PENDING for a subsequent commit.

## Structure
- Put the following in the shared package pa_rvfpm:
  - typedef enum for entry state
  - packed struct for entry payload {instr, id, rs, mode}
  - localparam for the pointer width
- One sub-module, rvfpm_early_commit_table, holding the macro-guarded id table. It is instantiated only under RVFPM_EARLY_COMMIT_EN.

## Test plan
- Issue id 3 (instr 0x00B57553, rs0=0x3F800000) with commit id 3 kill=0 in the same cycle; ex_ready=1 → ex_valid at next cycle, ex_id=3, ex_rs[0]=0x3F800000, count returns to 0.
- Fill DEPTH=4 with ids 0–3 without commits → full=1, issue_ready=0, ex_valid=0. Then commit 1, 0 → ex ids 0, 1 in order on consecutive cycles.
- Issue ids 5, 6; kill 5, commit 6 → id 5 never appears on ex, id 6 dispatched one cycle after the kill drain.
- ex_ready held 0 for 3 cycles on committed head → ex_valid and payload stable; pop on the first ex_ready=1 cycle.
- Early commit: commit id 7 two cycles before issuing id 7 → with the macro, ex_valid one cycle after issue. Without it, the entry remains PENDING until a new commit.
- Assert rst while 3 entries are queued → next cycle count=0, empty=1, ex_valid=0, and the early table is empty.
